// File: rtl/aes_ctr_pkg.sv
// AES-256-CTR scheduler shared types.
// Block width, FSM encoding and counter-block increment helper.
package aes_ctr_pkg;

  localparam int BLOCK_W = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    KEYEXP = 2'd1,
    RUN    = 2'd2,
    DRAIN  = 2'd3
  } sched_state_t;

  // Only the low ctr_width bits count; the nonce part never carries.
  function automatic logic [BLOCK_W-1:0] ctr_inc(
    input logic [BLOCK_W-1:0] blk,
    input int                 ctr_width
  );
    logic [BLOCK_W-1:0] mask;
    mask = '0;
    for (int i = 0; i < BLOCK_W; i++)
      if (i < ctr_width) mask[i] = 1'b1;
    return (blk & ~mask) | ((blk + BLOCK_W'(1)) & mask);
  endfunction

endpackage

// File: rtl/aes_ctr_sched_credit_counter.sv
// Outstanding-block credit counter for the CTR scheduler.
// Counts issued-but-unretired blocks; flags returns with nothing outstanding.
module credit_counter #(
  parameter int MAX = 16,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         avail,
  output logic         underflow_err
);

  assign avail = count < W'(MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      count         <= '0;
      underflow_err <= 1'b0;
    end else begin
      if (dec && count == '0)
        underflow_err <= 1'b1;
      unique case ({inc, dec})
        2'b10:   count <= count + W'(1);
        2'b01:   if (count != '0) count <= count - W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/aes_ctr_sched.sv
// AES-256-CTR message scheduler: optional rekey, then counter blocks
// streamed to the core under a bounded number of blocks in flight.
module aes_ctr_sched
  import aes_ctr_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 16,
  parameter int CTR_WIDTH       = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic               cfg_rekey,
  input  logic [BLOCK_W-1:0] cfg_iv,
  input  logic [31:0]        cfg_nblocks,
  output logic               kexp_start,
  input  logic               kexp_done,
  output logic [BLOCK_W-1:0] m_ctr_tdata,
  output logic               m_ctr_tvalid,
  output logic               m_ctr_tlast,
  input  logic               m_ctr_tready,
  input  logic               blk_ret,
  output logic               busy,
  output logic               done,
  output logic               credit_err
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  sched_state_t       state, state_n;
  logic [BLOCK_W-1:0] ctr;
  logic [31:0]        remaining;
  logic               done_q, done_n;
  logic               kstart_q, kstart_n;
  logic [CW-1:0]      outstanding;
  logic               avail;
  logic               accept;
  logic               hs;
  logic               drained;

  assign cfg_ready    = state == IDLE;
  assign busy         = state != IDLE;
  assign accept       = cfg_valid && cfg_ready;
  assign m_ctr_tvalid = (state == RUN) && avail;
  assign m_ctr_tlast  = (state == RUN) && (remaining == 32'd1);
  assign m_ctr_tdata  = ctr;
  assign hs           = m_ctr_tvalid && m_ctr_tready;
  assign done         = done_q;
  assign kexp_start   = kstart_q;

  // A return in this very cycle also empties the pipe.
  assign drained = (outstanding == '0) ||
                   (outstanding == CW'(1) && blk_ret);

  credit_counter #(
    .MAX (MAX_OUTSTANDING),
    .W   (CW)
  ) u_credit (
    .clk           (clk),
    .rst           (rst),
    .inc           (hs),
    .dec           (blk_ret),
    .count         (outstanding),
    .avail         (avail),
    .underflow_err (credit_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      done_q   <= 1'b0;
      kstart_q <= 1'b0;
    end else begin
      state    <= state_n;
      done_q   <= done_n;
      kstart_q <= kstart_n;
    end
  end

  always_comb begin
    state_n  = state;
    done_n   = 1'b0;
    kstart_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (cfg_nblocks == 32'd0) begin
            done_n = 1'b1;
          end else if (cfg_rekey) begin
            state_n  = KEYEXP;
            kstart_n = 1'b1;
          end else begin
            state_n = RUN;
          end
        end
      end
      // kexp_done during the start pulse belongs to a stale expansion
      KEYEXP: if (kexp_done && !kstart_q) state_n = RUN;
      RUN:    if (hs && m_ctr_tlast) state_n = DRAIN;
      DRAIN: begin
        if (drained) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctr       <= '0;
      remaining <= '0;
    end else if (accept) begin
      ctr       <= cfg_iv;
      remaining <= cfg_nblocks;
    end else if (hs) begin
      ctr       <= ctr_inc(ctr, CTR_WIDTH);
      remaining <= remaining - 32'd1;
    end
  end

endmodule

// File: tb/tb_aes_ctr_sched.sv
// Directed bench for aes_ctr_sched: vector table plus hand sequences
// for rekey timing, credit stall, empty message and mid-run reset.
module tb_aes_ctr_sched;

  localparam int MAXO = 4;
  localparam int NV   = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cfg_valid = 1'b0;
  logic         cfg_ready;
  logic         cfg_rekey = 1'b0;
  logic [127:0] cfg_iv = '0;
  logic [31:0]  cfg_nblocks = '0;
  logic         kexp_start;
  logic         kexp_done = 1'b0;
  logic [127:0] m_ctr_tdata;
  logic         m_ctr_tvalid;
  logic         m_ctr_tlast;
  logic         m_ctr_tready = 1'b1;
  logic         blk_ret;
  logic         busy;
  logic         done;
  logic         credit_err;
  logic         man_ret = 1'b0;
  logic         auto_ret = 1'b0;

  assign blk_ret = man_ret | auto_ret;

  always #5 clk = ~clk;

  aes_ctr_sched #(
    .MAX_OUTSTANDING (MAXO),
    .CTR_WIDTH       (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_rekey    (cfg_rekey),
    .cfg_iv       (cfg_iv),
    .cfg_nblocks  (cfg_nblocks),
    .kexp_start   (kexp_start),
    .kexp_done    (kexp_done),
    .m_ctr_tdata  (m_ctr_tdata),
    .m_ctr_tvalid (m_ctr_tvalid),
    .m_ctr_tlast  (m_ctr_tlast),
    .m_ctr_tready (m_ctr_tready),
    .blk_ret      (blk_ret),
    .busy         (busy),
    .done         (done),
    .credit_err   (credit_err)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  bit           auto_en = 1'b0;
  int           rdelay = 0;
  int           hold_until = 0;
  int           due[$];
  logic [127:0] got_d[$];
  logic         got_l[$];
  int           n_done = 0;
  int           done_cyc = -1;
  int           n_ks = 0;
  int           ks_cyc = -1;
  int           last_ret_cyc = -1;

  // Observer and auto-returner, mid-cycle after the driver settles.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (m_ctr_tvalid && m_ctr_tready) begin
        got_d.push_back(m_ctr_tdata);
        got_l.push_back(m_ctr_tlast);
        due.push_back(cyc + rdelay);
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (kexp_start) begin
        n_ks++;
        ks_cyc = cyc;
      end
      auto_ret = 1'b0;
      if (auto_en && due.size() > 0 && due[0] <= cyc &&
          cyc >= hold_until) begin
        auto_ret = 1'b1;
        last_ret_cyc = cyc;
        void'(due.pop_front());
      end
    end
  end

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chki(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic clear();
    due.delete();
    got_d.delete();
    got_l.delete();
    n_done = 0;
    done_cyc = -1;
    n_ks = 0;
    ks_cyc = -1;
    last_ret_cyc = -1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cfg_valid = 1'b0;
    kexp_done = 1'b0;
    man_ret = 1'b0;
    auto_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chki("rst_cfg_ready", int'(cfg_ready), 1);
    chki("rst_tvalid", int'(m_ctr_tvalid), 0);
    chki("rst_tlast", int'(m_ctr_tlast), 0);
    chki("rst_busy", int'(busy), 0);
    chki("rst_done", int'(done), 0);
    chki("rst_kexp_start", int'(kexp_start), 0);
    chki("rst_credit_err", int'(credit_err), 0);
    chk("rst_tdata", m_ctr_tdata, 128'h0);
    rst = 1'b0;
    clear();
  endtask

  task automatic send_cfg(logic [127:0] iv, int nb, bit rk);
    chki("cfg_ready_idle", int'(cfg_ready), 1);
    cfg_valid   = 1'b1;
    cfg_iv      = iv;
    cfg_nblocks = 32'(nb);
    cfg_rekey   = rk;
    @(negedge clk);
    cfg_valid = 1'b0;
    cfg_rekey = 1'b0;
  endtask

  task automatic wait_done(string name, int limit, int kdel);
    bit sent = 1'b0;
    int c = 0;
    while (n_done == 0 && c < limit) begin
      kexp_done = 1'b0;
      if (kdel >= 0 && !sent && n_ks > 0 && cyc >= ks_cyc + kdel) begin
        kexp_done = 1'b1;
        sent = 1'b1;
      end
      @(negedge clk);
      c++;
    end
    kexp_done = 1'b0;
    total++;
    if (n_done == 0) begin
      bad++;
      $display("FAIL %s: no done within %0d cycles", name, limit);
    end
  endtask

  typedef struct {
    logic [127:0]     iv;
    int               nb;
    bit               rekey;
    int               kdel;
    int               rdel;
    logic [3:0][31:0] e;
    logic [95:0]      up;
  } vec_t;

  vec_t vecs[NV];

  initial begin
    logic [127:0] d;
    logic [127:0] iv2;
    int           c;

    vecs[0] = '{128'h5, 3, 1'b0, -1, 20,
                {32'h0, 32'h7, 32'h6, 32'h5}, 96'h0};
    vecs[1] = '{{96'hA5A5A5A5_A5A5A5A5_A5A5A5A5, 32'hFFFF_FFFE}, 4, 1'b0,
                -1, 5,
                {32'h1, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
                96'hA5A5A5A5_A5A5A5A5_A5A5A5A5};
    vecs[2] = '{{96'h01234567_89ABCDEF_00112233, 32'h0000_0100}, 2, 1'b1,
                6, 2,
                {32'h0, 32'h0, 32'h101, 32'h100},
                96'h01234567_89ABCDEF_00112233};
    vecs[3] = '{{96'hDEADBEEF_CAFEF00D_12345678, 32'h7FFF_FFFF}, 10, 1'b0,
                -1, 20,
                {32'h8000_0002, 32'h8000_0001, 32'h8000_0000, 32'h7FFF_FFFF},
                96'hDEADBEEF_CAFEF00D_12345678};

    do_reset();

    for (int v = 0; v < NV; v++) begin
      clear();
      rdelay = vecs[v].rdel;
      hold_until = 0;
      auto_en = 1'b1;
      send_cfg(vecs[v].iv, vecs[v].nb, vecs[v].rekey);
      wait_done($sformatf("v%0d_done", v), 1000, vecs[v].kdel);
      chki($sformatf("v%0d_nblk", v), got_d.size(), vecs[v].nb);
      for (int k = 0; k < got_d.size(); k++) begin
        d = got_d[k];
        if (k < 4)
          chk($sformatf("v%0d_low%0d", v, k),
              {96'h0, d[31:0]}, {96'h0, vecs[v].e[k]});
        chk($sformatf("v%0d_up%0d", v, k),
            {32'h0, d[127:32]}, {32'h0, vecs[v].up});
        chki($sformatf("v%0d_tlast%0d", v, k),
             int'(got_l[k]), int'(k == vecs[v].nb - 1));
      end
      chki($sformatf("v%0d_done_gap", v), done_cyc, last_ret_cyc + 1);
      chki($sformatf("v%0d_ndone", v), n_done, 1);
      chki($sformatf("v%0d_kexp_cnt", v), n_ks, int'(vecs[v].rekey));
      chki($sformatf("v%0d_cerr", v), int'(credit_err), 0);
    end

    // rekey: start-cycle kexp_done ignored, tvalid follows the real one
    clear();
    rdelay = 2;
    auto_en = 1'b1;
    send_cfg(128'h77, 1, 1'b1);
    chki("kx_start_pulse", int'(kexp_start), 1);
    chki("kx_tvalid0", int'(m_ctr_tvalid), 0);
    chki("kx_busy", int'(busy), 1);
    kexp_done = 1'b1;
    @(negedge clk);
    kexp_done = 1'b0;
    chki("kx_start_low", int'(kexp_start), 0);
    chki("kx_early_ignored", int'(m_ctr_tvalid), 0);
    c = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (m_ctr_tvalid) c++;
    end
    chki("kx_no_early_tvalid", c, 0);
    kexp_done = 1'b1;
    @(negedge clk);
    kexp_done = 1'b0;
    chki("kx_tvalid_rise", int'(m_ctr_tvalid), 1);
    wait_done("kx_done", 200, -1);
    chki("kx_start_once", n_ks, 1);
    chk("kx_tdata", got_d.size() > 0 ? got_d[0] : 128'hX, 128'h77);

    // credit stall: no returns, only MAXO blocks may issue
    clear();
    auto_en = 1'b0;
    rdelay = 0;
    hold_until = 0;
    send_cfg(128'h40, 10, 1'b0);
    repeat (30) @(negedge clk);
    chki("stall_issued", got_d.size(), MAXO);
    chki("stall_tvalid", int'(m_ctr_tvalid), 0);
    for (int r = 0; r < 3; r++) begin
      man_ret = 1'b1;
      void'(due.pop_front());
      @(negedge clk);
      man_ret = 1'b0;
      chki($sformatf("free%0d_tvalid", r), int'(m_ctr_tvalid), 1);
      @(negedge clk);
      chki($sformatf("free%0d_tvalid_off", r), int'(m_ctr_tvalid), 0);
      chki($sformatf("free%0d_issued", r), got_d.size(), MAXO + 1 + r);
    end
    auto_en = 1'b1;
    wait_done("stall_done", 500, -1);
    chki("stall_total", got_d.size(), 10);
    d = got_d.size() == 10 ? got_d[9] : 128'h0;
    chk("stall_last_data", d, 128'h49);
    chki("stall_cerr", int'(credit_err), 0);

    // empty message, then a return with nothing outstanding
    clear();
    auto_en = 1'b0;
    send_cfg(128'h99, 0, 1'b0);
    chki("empty_done", int'(done), 1);
    chki("empty_tvalid", int'(m_ctr_tvalid), 0);
    chki("empty_busy", int'(busy), 0);
    @(negedge clk);
    chki("empty_done_pulse", int'(done), 0);
    chki("empty_no_issue", got_d.size(), 0);
    man_ret = 1'b1;
    @(negedge clk);
    man_ret = 1'b0;
    chki("cerr_set", int'(credit_err), 1);
    repeat (5) @(negedge clk);
    chki("cerr_sticky", int'(credit_err), 1);

    // reset mid-run after two blocks, then a fresh short message
    clear();
    rdelay = 20;
    auto_en = 1'b1;
    send_cfg(128'hCAFE_0000_0000_0000_0000_0000_0000_0010, 8, 1'b0);
    c = 0;
    while (got_d.size() < 2 && c < 50) begin
      @(negedge clk);
      c++;
    end
    chki("abort_two_issued", got_d.size(), 2);
    do_reset();
    repeat (5) @(negedge clk);
    chki("abort_no_done", n_done, 0);
    chki("abort_idle", int'(busy), 0);
    clear();
    rdelay = 3;
    auto_en = 1'b1;
    iv2 = 128'h1111_2222_3333_4444_5555_6666_FFFF_FFFF;
    send_cfg(iv2, 2, 1'b0);
    wait_done("post_rst_done", 200, -1);
    chki("post_rst_nblk", got_d.size(), 2);
    if (got_d.size() == 2) begin
      chk("post_rst_d0", got_d[0], iv2);
      chk("post_rst_d1", got_d[1],
          128'h1111_2222_3333_4444_5555_6666_0000_0000);
      chki("post_rst_l0", int'(got_l[0]), 0);
      chki("post_rst_l1", int'(got_l[1]), 1);
    end
    chki("post_rst_ndone", n_done, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_ctr_sched.md
Name: aes_ctr_sched

Overview:
Sequences one AES-256-CTR message through the AES core. Accepts a per-message IV, block count and optional rekey request, and triggers key expansion when requested. Then issues the counter blocks as an AXI-Stream to the core input, with tlast on the final block. A credit counter bounds the number of blocks in flight so the downstream keystream/ciphertext buffer can never overflow, even when the output consumer stalls.

Parameters:
MAX_OUTSTANDING, 16, maximum blocks issued but not yet returned (retired) downstream; range 1..255
CTR_WIDTH, 32, number of low IV bits that increment; the upper 128-CTR_WIDTH bits stay fixed

Ports:
clk  in  1  clock
rst  in  1  reset
cfg_valid  in  1  message config valid
cfg_ready  out  1  config accepted when cfg_valid && cfg_ready
cfg_rekey  in  1  run key expansion before the message
cfg_iv  in  128  initial counter block
cfg_nblocks  in  32  number of 128-bit blocks in the message
kexp_start  out  1  one-cycle pulse that starts key expansion
kexp_done  in  1  key expansion complete (pulse or level, sampled in KEYEXP only)
m_ctr_tdata  out  128  counter block to the AES core
m_ctr_tvalid  out  1  counter block valid
m_ctr_tlast  out  1  final block of the message
m_ctr_tready  in  1  core ready
blk_ret  in  1  one block retired downstream (one credit returned)
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when a message is fully retired
credit_err  out  1  sticky flag: blk_ret arrived while outstanding==0

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk. Reset values: cfg_ready=1, all other outputs 0, outstanding=0, FSM=IDLE. Reset mid-message aborts the message; no done pulse is generated.
- FSM states: IDLE, KEYEXP, RUN, DRAIN.
- IDLE: cfg_ready=1. On accept, latch ctr=cfg_iv, remaining=cfg_nblocks, then:
  - nblocks==0: done pulse next cycle, stay IDLE.
  - cfg_rekey=1: kexp_start pulse next cycle, go to KEYEXP.
  - otherwise: go to RUN; m_ctr_tvalid goes high the next cycle (1-cycle latency).
- cfg_ready=0 in every other state.
- KEYEXP: wait for kexp_done=1, then go to RUN. A kexp_done seen in the same cycle as kexp_start is ignored; kexp_done is only counted from the cycle after the pulse.
- RUN:
  - m_ctr_tvalid=1 whenever outstanding < MAX_OUTSTANDING.
  - AXI rules: once asserted, tvalid is held with tdata/tlast stable until tready.
  - m_ctr_tlast=1 when remaining==1.
  - On a handshake: ctr low CTR_WIDTH bits += 1 modulo 2^CTR_WIDTH (wrap to 0, upper bits untouched), remaining -= 1, outstanding += 1.
  - The handshake that carries tlast moves the FSM to DRAIN.
- Credits:
  - Handshake and blk_ret in the same cycle: outstanding unchanged.
  - blk_ret alone: outstanding -= 1.
  - blk_ret with outstanding==0: outstanding stays 0 and credit_err is set; it clears only on rst.
  - blk_ret is honoured in every state.
- DRAIN: when outstanding reaches 0 (including via blk_ret this cycle), pulse done for one cycle and go to IDLE.
- A back-to-back config can be accepted in the cycle after done.
- Throughput: one block per cycle while credits are available and tready=1.

Decomposition:
- Package aes_ctr_pkg holds:
  - block width constant BLOCK_W=128
  - state enum type sched_state_t {IDLE,KEYEXP,RUN,DRAIN}
  - function ctr_inc(block, CTR_WIDTH)
- Sub-module credit_counter (params MAX; ports inc, dec, count, avail, underflow_err) holds the outstanding counter.

Test Plan:
1. iv=0x...0000_0000_0000_0005, nblocks=3, no rekey, tready=1, blk_ret 20 cycles after each issue → tdata 5,6,7; tlast only on 7; done one cycle after the third blk_ret.
2. iv low word 0xFFFFFFFE, upper 96 bits 0xA5..A5, nblocks=4 → low word sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001; upper bits unchanged.
3. MAX_OUTSTANDING=4, nblocks=10, no blk_ret until cycle 30 → exactly 4 blocks issued, tvalid=0 from then on; each later blk_ret frees exactly one further issue.
4. cfg_rekey=1, kexp_done asserted 14 cycles after kexp_start → tvalid rises the cycle after kexp_done and no earlier; kexp_start pulses exactly once.
5. nblocks=0 → no tvalid; done one cycle after accept. Separately: blk_ret with outstanding=0 → credit_err=1, which holds until rst.
6. rst asserted mid-RUN after 2 of 8 blocks, then a new cfg with nblocks=2 → all outputs reset, no done for the aborted message; the new message issues its IV and IV+1 with correct tlast and done.
